accum_delta_decoder: RTL and testbench



---
 rtl/accum_delta_decoder_pkg.sv | 16 +
 rtl/delta_fifo.sv | 52 +++++
 rtl/accum_delta_decoder.sv | 124 ++++++++++++
 tb/tb_accum_delta_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/accum_delta_decoder_pkg.sv
// rtl/accum_delta_decoder_pkg.sv - shared defaults, FSM encoding and FIFO entry layout
package accum_delta_decoder_pkg;

    localparam int WIDTH_D = 8;
    localparam int RUN_W_D = 4;
    localparam int DEPTH_D = 2;

    // Entry layout: zero-run count in the low bits, delta directly above it.
    localparam int ZRUN_LSB = 0;

    typedef enum logic {
        ST_ACTIVE     = 1'b0,
        ST_FLUSH_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/delta_fifo.sv
// rtl/delta_fifo.sv - small synchronous FIFO with full/empty flags
module delta_fifo #(
    parameter int W       = 12,
    parameter int DEPTH_P = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

    logic [W-1:0]  mem [DEPTH_P];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH_P));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a nonzero count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/accum_delta_decoder.sv
// rtl/accum_delta_decoder.sv - recovers non-zero increments and zero runs from a running-sum stream
module accum_delta_decoder
    import accum_delta_decoder_pkg::*;
#(
    parameter int WIDTH_P = WIDTH_D,
    parameter int RUN_W_P = RUN_W_D,
    parameter int DEPTH_P = DEPTH_D
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sum_valid_i,
    output logic               sum_ready_o,
    input  logic [WIDTH_P-1:0] sum_i,
    input  logic               flush_i,
    input  logic               resync_i,
    output logic               delta_valid_o,
    input  logic               delta_ready_i,
    output logic [WIDTH_P-1:0] delta_o,
    output logic [RUN_W_P-1:0] zrun_o
);

    localparam int EW = WIDTH_P + RUN_W_P;
    localparam logic [RUN_W_P-1:0] MAX_RUN = '1;

    state_t             state, state_n;
    logic [WIDTH_P-1:0] baseline, baseline_n;
    logic [WIDTH_P-1:0] d;
    logic [RUN_W_P-1:0] run, run_n;
    logic               rflag, rflag_n, resync_eff;
    logic               accept;
    logic               push;
    logic [EW-1:0]      push_data;
    logic [EW-1:0]      pop_data;
    logic               fifo_full;
    logic               fifo_empty;

    assign sum_ready_o = !fifo_full && (state == ST_ACTIVE);
    assign accept      = sum_valid_i && sum_ready_o;
    assign d           = sum_i - baseline;
    assign resync_eff  = rflag || resync_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_ACTIVE;
            baseline <= '0;
            run      <= '0;
            rflag    <= 1'b0;
        end else begin
            state    <= state_n;
            baseline <= baseline_n;
            run      <= run_n;
            rflag    <= rflag_n;
        end
    end

    always_comb begin
        state_n    = state;
        baseline_n = baseline;
        run_n      = run;
        rflag_n    = resync_eff;
        push       = 1'b0;
        push_data  = '0;
        if (state == ST_FLUSH_PEND) begin
            if (!fifo_full) begin
                if (run != '0) begin
                    push      = 1'b1;
                    push_data = {{WIDTH_P{1'b0}}, run - 1'b1};
                    run_n     = '0;
                end
                state_n = ST_ACTIVE;
            end
        end else begin
            if (accept) begin
                baseline_n = sum_i;
                if (resync_eff) begin
                    rflag_n = 1'b0;
                end else if (d != '0) begin
                    push      = 1'b1;
                    push_data = {d, run};
                    run_n     = '0;
                end else if (run == MAX_RUN) begin
                    push      = 1'b1;
                    push_data = {{WIDTH_P{1'b0}}, MAX_RUN};
                    run_n     = '0;
                end else begin
                    run_n = run + 1'b1;
                end
            end
            // A flush that cannot go out this cycle is parked until the FIFO has room.
            if (flush_i) begin
                if (accept) begin
                    state_n = ST_FLUSH_PEND;
                end else if (run != '0) begin
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_data = {{WIDTH_P{1'b0}}, run - 1'b1};
                        run_n     = '0;
                    end else begin
                        state_n = ST_FLUSH_PEND;
                    end
                end
            end
        end
    end

    delta_fifo #(
        .W       (EW),
        .DEPTH_P (DEPTH_P)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (delta_ready_i),
        .data_o      (pop_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign delta_valid_o = !fifo_empty;
    assign zrun_o        = pop_data[ZRUN_LSB +: RUN_W_P];
    assign delta_o       = pop_data[ZRUN_LSB + RUN_W_P +: WIDTH_P];

endmodule

// File: tb/tb_accum_delta_decoder.sv
// tb/tb_accum_delta_decoder.sv - scoreboard bench for accum_delta_decoder
module tb_accum_delta_decoder;

    localparam int W     = 8;
    localparam int RW    = 4;
    localparam int DEPTH = 2;
    localparam int MAXR  = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sum_valid = 1'b0;
    logic          sum_ready;
    logic [W-1:0]  sum = '0;
    logic          flush = 1'b0;
    logic          resync = 1'b0;
    logic          delta_valid;
    logic          delta_ready = 1'b0;
    logic [W-1:0]  delta;
    logic [RW-1:0] zrun;

    accum_delta_decoder #(.WIDTH_P(W), .RUN_W_P(RW), .DEPTH_P(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sum_valid_i   (sum_valid),
        .sum_ready_o   (sum_ready),
        .sum_i         (sum),
        .flush_i       (flush),
        .resync_i      (resync),
        .delta_valid_o (delta_valid),
        .delta_ready_i (delta_ready),
        .delta_o       (delta),
        .zrun_o        (zrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected entries, oldest first, each packed as {delta, zrun}.
    logic [W+RW-1:0] exp_q[$];

    // Reference state: last sum seen, pending zero count, resync/flush requests, FIFO occupancy.
    int m_base, m_run, m_occ;
    bit m_rflag, m_pend;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_base = 0; m_run = 0; m_occ = 0; m_rflag = 0; m_pend = 0;
        exp_q.delete();
    endfunction

    function automatic int emit(int dv, int z);
        exp_q.push_back({W'(dv), RW'(z)});
        return 1;
    endfunction

    // One clock: check visible state, drive inputs, advance the reference over the coming edge.
    task automatic cyc(input bit v, input int s, input bit f, input bit r, input bit dr, output bit acc);
        bit full, rf;
        int pushes, dd;
        @(posedge clk); #1;
        chk("sum_ready", int'(sum_ready), int'(!m_pend && m_occ < DEPTH));
        chk("delta_valid", int'(delta_valid), int'(m_occ > 0));
        sum_valid = v; sum = W'(s); flush = f; resync = r; delta_ready = dr;
        full = (m_occ == DEPTH);
        acc = v && !m_pend && !full;
        rf = m_rflag || r;
        pushes = 0;
        if (m_pend) begin
            if (!full) begin
                if (m_run > 0) begin pushes += emit(0, m_run - 1); m_run = 0; end
                m_pend = 0;
            end
        end else begin
            if (acc) begin
                dd = (s - m_base) % 256;
                if (dd < 0) dd += 256;
                m_base = s % 256;
                if (rf) ;
                else if (dd != 0) begin pushes += emit(dd, m_run); m_run = 0; end
                else if (m_run == MAXR) begin pushes += emit(0, MAXR); m_run = 0; end
                else m_run++;
            end
            if (f) begin
                if (acc) m_pend = 1;
                else if (m_run > 0) begin
                    if (!full) begin pushes += emit(0, m_run - 1); m_run = 0; end
                    else m_pend = 1;
                end
            end
        end
        m_rflag = (acc && rf) ? 1'b0 : rf;
        m_occ = m_occ - int'(dr && m_occ > 0) + pushes;
    endtask

    task automatic send(input int s, input bit dr, input bit f, input bit r);
        bit acc;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) cyc(1, s, f, r, dr, acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input bit dr);
        bit acc;
        repeat (n) cyc(0, 0, 0, 0, dr, acc);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; sum_valid = 0; flush = 0; resync = 0;
        #1;
        chk("rst_delta_valid", int'(delta_valid), 0);
        chk("rst_sum_ready", int'(sum_ready), 1);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Monitor: pops on every handshake and checks held outputs under back-pressure.
    logic            hold_v = 1'b0;
    logic [W+RW-1:0] hold_d = '0;
    logic [W+RW-1:0] exp_e;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", int'(delta_valid), 1);
                chk("hold_data", int'({delta, zrun}), int'(hold_d));
            end
            if (delta_valid && delta_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", int'({delta, zrun}), -1);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("delta", int'(delta), int'(exp_e[RW +: W]));
                    chk("zrun", int'(zrun), int'(exp_e[0 +: RW]));
                end
            end
            hold_v = delta_valid && !delta_ready;
            hold_d = {delta, zrun};
        end
    end

    initial begin
        bit acc;
        int s;
        model_reset();
        #12;
        chk("init_delta_valid", int'(delta_valid), 0);
        chk("init_sum_ready", int'(sum_ready), 1);
        @(posedge clk); #1;
        rst = 0;

        send(5, 1, 0, 0); send(5, 1, 0, 0); send(5, 1, 0, 0); send(12, 1, 0, 0);
        send(250, 1, 0, 0); send(3, 1, 0, 0);
        send(0, 1, 0, 0);
        repeat (17) send(0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, acc);
        idle(2, 1);

        send(10, 0, 0, 0); send(20, 0, 0, 0);
        repeat (3) cyc(1, 30, 0, 0, 0, acc);
        send(30, 1, 0, 0);
        idle(3, 1);

        repeat (3) send(30, 1, 0, 0);
        send(30, 1, 1, 0);
        idle(3, 1);

        send(10, 1, 0, 0); send(40, 1, 0, 1); send(45, 1, 0, 0);
        idle(2, 1);

        send(77, 0, 0, 0); send(1, 0, 0, 0);
        do_reset();
        send(9, 1, 0, 0);
        idle(2, 1);

        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(0, 2) == 0) ? m_base : int'($urandom_range(0, 255));
            cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 15) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, acc);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1);
        idle(2, 1);
        chk("drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
